dynamic_shreg_mc: RTL

//   Multi-channel, variable-tap delay line with valid tracking, for aligning
//   EKF datapath operands whose pipeline latencies differ at run time.
//   NCH lanes share one clock-enable and one valid chain. Each lane has its own
//   tap address. An occupancy counter and a synchronous flush let the

---
 rtl/dynamic_shreg_mc.sv | 97 +++++++++
 1 files changed

// File: rtl/dynamic_shreg_mc.sv
// Multi-channel variable-tap delay line with a shared valid chain and occupancy count.
// Used to realign datapath operands whose pipeline latencies differ at run time.
module dynamic_shreg_mc #(
    parameter int DW   = 16,
    parameter int AW   = 5,
    parameter int NCH  = 4,
    parameter int OREG = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ce,
    input  logic              flush,
    input  logic              din_vld,
    input  logic [NCH*DW-1:0] din,
    input  logic [NCH*AW-1:0] addr,
    output logic [NCH*DW-1:0] dout,
    output logic [NCH-1:0]    dout_vld,
    output logic [AW:0]       fill
);

    localparam int DEPTH = 2**AW;
    localparam logic [AW:0] FILL_ONE = {{AW{1'b0}}, 1'b1};

    // Index 0 holds stage 1, index DEPTH-1 holds stage DEPTH.
    logic [DW-1:0]     sr_r [NCH][DEPTH];
    logic [DEPTH-1:0]  vld_r;
    logic [AW:0]       fill_r;
    logic [NCH*DW-1:0] tap_dat_s;
    logic [NCH-1:0]    tap_vld_s;

    // Data stages shift on ce and carry no reset so they map onto shift-register primitives
    always_ff @(posedge clk) begin
        if (ce) begin
            for (int c = 0; c < NCH; c++) begin
                sr_r[c][0] <= din[c*DW +: DW];
                for (int i = 1; i < DEPTH; i++) begin
                    sr_r[c][i] <= sr_r[c][i-1];
                end
            end
        end
    end

    // Valid chain and occupancy; flush drops the incoming tag along with the chain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_r  <= '0;
            fill_r <= '0;
        end else if (flush) begin
            vld_r  <= '0;
            fill_r <= '0;
        end else if (ce) begin
            vld_r <= {vld_r[DEPTH-2:0], din_vld};
            case ({din_vld, vld_r[DEPTH-1]})
                2'b10:   fill_r <= fill_r + FILL_ONE;
                2'b01:   fill_r <= fill_r - FILL_ONE;
                default: fill_r <= fill_r;
            endcase
        end
    end

    // Per-channel tap multiplexer; delay is addr+1 stages
    always_comb begin
        tap_dat_s = '0;
        tap_vld_s = '0;
        for (int c = 0; c < NCH; c++) begin
            tap_dat_s[c*DW +: DW] = sr_r[c][addr[c*AW +: AW]];
            tap_vld_s[c]          = vld_r[addr[c*AW +: AW]];
        end
    end

    generate
        if (OREG != 0) begin : g_oreg
            logic [NCH*DW-1:0] dout_r;
            logic [NCH-1:0]    dout_vld_r;

            // Output register follows the tap every clock, independent of ce
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    dout_r     <= '0;
                    dout_vld_r <= '0;
                end else begin
                    dout_r     <= tap_dat_s;
                    dout_vld_r <= flush ? {NCH{1'b0}} : tap_vld_s;
                end
            end

            assign dout     = dout_r;
            assign dout_vld = dout_vld_r;
        end else begin : g_comb
            assign dout     = tap_dat_s;
            assign dout_vld = tap_vld_s;
        end
    endgenerate

    assign fill = fill_r;

endmodule
